// File: rtl/noc_link_pkg.sv
// Shared link-layer constants and tx FSM encoding for the NoC link transmitter and receiver.
package noc_link_pkg;

    localparam int FLIT_W         = 64;
    localparam int PHIT_W         = 16;
    localparam int PHITS_PER_FLIT = 4;
    localparam int PHIT_IDX_W     = $clog2(PHITS_PER_FLIT);

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_SEND = 1'b1
    } tx_state_e;

    function automatic logic phit_parity(input logic [PHIT_W-1:0] phit);
        return ^phit;
    endfunction

endpackage

// File: rtl/noc_link_tx_phit_serializer.sv
// Flit-to-phit shift register: load captures a whole flit, shift exposes the next 16-bit phit.
module phit_serializer
    import noc_link_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_load,
    input  logic              i_shift,
    input  logic [FLIT_W-1:0] i_flit,
    output logic [PHIT_W-1:0] o_phit,
    output logic              o_last
);

    logic [FLIT_W-1:0]     r_shreg;
    logic [PHIT_IDX_W-1:0] r_phit_idx;

    // A load wins over a shift: on a back-to-back final phit the next flit replaces the old one.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_shreg    <= '0;
            r_phit_idx <= '0;
        end else if (i_load) begin
            r_shreg    <= i_flit;
            r_phit_idx <= '0;
        end else if (i_shift) begin
            r_shreg    <= {{PHIT_W{1'b0}}, r_shreg[FLIT_W-1:PHIT_W]};
            r_phit_idx <= r_phit_idx + 1'b1;
        end
    end

    assign o_phit = r_shreg[PHIT_W-1:0];
    assign o_last = (r_phit_idx == PHIT_IDX_W'(PHITS_PER_FLIT - 1));

endmodule

// File: rtl/noc_link_tx.sv
// Router output-port link transmitter: pops 64-bit flits from the show-ahead FIFO and sends 4 phits LSB first.
// Optional NOC_LINK_TX_PARITY_EN adds the link_parity output (even parity of link_data).
module noc_link_tx
    import noc_link_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              tx_en,
    input  logic              fifo_empty,
    input  logic [FLIT_W-1:0] fifo_data,
    output logic              fifo_rd_en,
    output logic              link_valid,
    input  logic              link_ready,
    output logic [PHIT_W-1:0] link_data,
    output logic              link_last,
    output logic [15:0]       tx_flit_cnt,
    output tx_state_e         dbg_state
`ifdef NOC_LINK_TX_PARITY_EN
    ,
    output logic              link_parity
`endif
);

    tx_state_e         r_state;
    logic [15:0]       r_flit_cnt;
    logic              w_send;
    logic              w_xfer;
    logic              w_last;
    logic              w_final;
    logic              w_pop;
    logic [PHIT_W-1:0] w_phit;

    // Link handshake: a phit moves when link_valid && link_ready; while valid is high and ready is low,
    // valid, data and last hold unchanged for as long as the receiver stalls.
    assign w_send  = (r_state == TX_SEND);
    assign w_xfer  = w_send && link_ready;
    assign w_final = w_xfer && w_last;
    // Gating with reset_n keeps the FIFO from being popped while the block is held in reset.
    assign w_pop   = reset_n && tx_en && !fifo_empty && (!w_send || w_final);

    phit_serializer u_ser (
        .i_clk     (clk),
        .i_reset_n (reset_n),
        .i_load    (w_pop),
        .i_shift   (w_xfer && !w_last),
        .i_flit    (fifo_data),
        .o_phit    (w_phit),
        .o_last    (w_last)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= TX_IDLE;
            r_flit_cnt <= '0;
        end else begin
            case (r_state)
                TX_IDLE: begin
                    if (w_pop) r_state <= TX_SEND;
                end
                TX_SEND: begin
                    if (w_final) begin
                        r_flit_cnt <= r_flit_cnt + 16'd1;
                        if (!w_pop) r_state <= TX_IDLE;
                    end
                end
                default: r_state <= TX_IDLE;
            endcase
        end
    end

    assign fifo_rd_en  = w_pop;
    assign link_valid  = w_send;
    assign link_data   = w_send ? w_phit : '0;
    assign link_last   = w_send && w_last;
    assign tx_flit_cnt = r_flit_cnt;
    assign dbg_state   = r_state;

`ifdef NOC_LINK_TX_PARITY_EN
    assign link_parity = phit_parity(link_data);
`endif

endmodule
